// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/execute core:
//   - opcode values (OP_NOP .. OP_HALT) and the reserved opcode window
//   - register indices R0..R3
//   - control state enum {FILL, RUN, HALT}
//   - instruction field slice positions
//   - small decode helper functions
// -----------------------------------------------------------------------------
package decode_pkg;

    // Instruction word width and field positions
    localparam int INSTR_W = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 2;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;
    localparam int TGT_MSB = 3;
    localparam int TGT_LSB = 0;

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_INC  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_RSV_LO = 4'h7;
    localparam logic [3:0] OP_RSV_HI = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Register indices
    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    // Control state
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Opcodes that write a register and update the zero flag
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_INC) && (op <= OP_XOR);
    endfunction

    // Opcodes reserved for future use
    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= OP_RSV_LO) && (op <= OP_RSV_HI);
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// -----------------------------------------------------------------------------
// regfile_4x8
// Four DATA_W-bit registers, asynchronously cleared by rst_i.
// Two combinational read ports (A, B) and one synchronous write port.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   ra_addr_i / ra_data_o   read port A
//   rb_addr_i / rb_data_o   read port B
//   wr_en_i, wr_addr_i,     write port, committed at the rising edge
//   wr_data_i
// -----------------------------------------------------------------------------
module regfile_4x8 #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [1:0]        rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] regs_q [4];

    // Register storage with async clear and single write port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read ports
    always_comb begin
        ra_data_o = regs_q[ra_addr_i];
        rb_data_o = regs_q[rb_addr_i];
    end

endmodule

// File: rtl/decode_exec.sv
// -----------------------------------------------------------------------------
// decode_exec
// Two-stage decode/execute core sitting at the consumer end of the fetch ROM.
//   Stage 1: IR <= instruction, tagged with the shadow copy of the fetch PC.
//   Stage 2: decode IR and execute against a 4 x DATA_W register file and a
//            zero flag; branches are resolved here and squash the single
//            wrong-path fetch that is already in flight.
// HALT keeps the fetch PC frozen by branching to its own address every cycle.
//
// Optional build macro: DECODE_ILLEGAL_TRAP_EN
//   defined   - reserved opcodes 7..B halt like HALT and set the sticky
//               `illegal` output
//   undefined - reserved opcodes are NOPs and `illegal` does not exist
//
// Ports:
//   clk            system clock, rising edge
//   rst            async active-high reset
//   instruction    fetched word: [7:4] opcode, [3:2] rd, [1:0] rs, [3:0] target
//   branch         comb; fetch PC loads branchaddress at the next edge
//   branchaddress  branch target, 0 when branch=0
//   reg_wr_en      register-file write strobe (comb, stage 2)
//   reg_wr_addr    write index
//   reg_wr_data    write data
//   zero           registered zero flag
//   halted         high while in HALT
//   illegal        (macro only) sticky reserved-opcode trap flag
// -----------------------------------------------------------------------------
module decode_exec
    import decode_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instruction,
    output logic              branch,
    output logic [PC_W-1:0]   branchaddress,
    output logic              reg_wr_en,
    output logic [1:0]        reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              zero,
    output logic              halted
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    // ---------------------------------------------------------------- state
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;            // shadow of the fetch ROM's PC
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]   ir_pc_q;
    logic              ir_valid_q, ir_valid_d;
    logic              zero_q, zero_d;
    logic [PC_W-1:0]   halt_pc_q, halt_pc_d;  // address the core spins on in HALT

    // ---------------------------------------------------------------- decode
    logic [3:0]        op_s;
    logic [1:0]        rd_s, rs_s;
    logic [PC_W-1:0]   tgt_s;
    logic              exec_s;
    logic              halt_hit_s;
    logic [DATA_W-1:0] rd_val_s, rs_val_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_wr_s;

    assign op_s  = ir_q[OPC_MSB:OPC_LSB];
    assign rd_s  = ir_q[RD_MSB:RD_LSB];
    assign rs_s  = ir_q[RS_MSB:RS_LSB];
    assign tgt_s = ir_q[PC_W-1:0];

    // Stage 2 only acts on a live (non-squashed) instruction while running
    assign exec_s = ir_valid_q && (state_q == RUN);

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign halt_hit_s = exec_s && ((op_s == OP_HALT) || is_reserved(op_s));
    assign illegal    = illegal_q;
`else
    assign halt_hit_s = exec_s && (op_s == OP_HALT);
`endif

    regfile_4x8 #(
        .DATA_W (DATA_W)
    ) u_rf (
        .clk_i     (clk),
        .rst_i     (rst),
        .ra_addr_i (rd_s),
        .ra_data_o (rd_val_s),
        .rb_addr_i (rs_s),
        .rb_data_o (rs_val_s),
        .wr_en_i   (reg_wr_en),
        .wr_addr_i (reg_wr_addr),
        .wr_data_i (reg_wr_data)
    );

    // ALU: modulo-2^DATA_W arithmetic, carry/borrow dropped
    always_comb begin
        alu_res_s = '0;
        case (op_s)
            OP_INC:  alu_res_s = rd_val_s + DATA_W'(1);
            OP_ADD:  alu_res_s = rd_val_s + rs_val_s;
            OP_SUB:  alu_res_s = rd_val_s - rs_val_s;
            OP_MOV:  alu_res_s = rs_val_s;
            OP_AND:  alu_res_s = rd_val_s & rs_val_s;
            OP_XOR:  alu_res_s = rd_val_s ^ rs_val_s;
            default: alu_res_s = '0;
        endcase
        alu_wr_s = exec_s && is_alu_op(op_s);
    end

    // ------------------------------------------------------------------ FSM
    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; HALT is left only through rst
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: state_d = RUN;
            RUN: begin
                if (halt_hit_s) begin
                    state_d = HALT;
                end else begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FILL;
        endcase
    end

    // FSM outputs: branch resolution, write strobe, halted
    always_comb begin
        branch        = 1'b0;
        branchaddress = '0;
        reg_wr_en     = alu_wr_s;
        reg_wr_addr   = rd_s;
        reg_wr_data   = alu_res_s;
        halted        = 1'b0;
        case (state_q)
            HALT: begin
                // Spin on the HALT's own address so fetch stays frozen
                branch        = 1'b1;
                branchaddress = halt_pc_q;
                halted        = 1'b1;
                reg_wr_en     = 1'b0;
            end
            RUN: begin
                if (halt_hit_s) begin
                    // Branch to self already in the executing cycle so the
                    // fetch PC never runs past the HALT
                    branch        = 1'b1;
                    branchaddress = ir_pc_q;
                end else if (exec_s) begin
                    case (op_s)
                        OP_JMP: begin
                            branch        = 1'b1;
                            branchaddress = tgt_s;
                        end
                        OP_JZ: begin
                            if (zero_q) begin
                                branch        = 1'b1;
                                branchaddress = tgt_s;
                            end else begin
                                branch        = 1'b0;
                            end
                        end
                        OP_JNZ: begin
                            if (!zero_q) begin
                                branch        = 1'b1;
                                branchaddress = tgt_s;
                            end else begin
                                branch        = 1'b0;
                            end
                        end
                        default: branch = 1'b0;
                    endcase
                end else begin
                    branch = 1'b0;
                end
            end
            FILL:    branch = 1'b0;
            default: branch = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // Next-state for shadow PC, IR valid, zero flag and HALT address
    always_comb begin
        // Mirror the fetch ROM's PC exactly so ir_pc names the IR's address
        if (branch) begin
            pc_d = branchaddress;
        end else begin
            pc_d = pc_q + PC_W'(1);
        end
        // A branch at this edge squashes the wrong-path word being latched
        if (branch || (state_q == HALT)) begin
            ir_valid_d = 1'b0;
        end else begin
            ir_valid_d = 1'b1;
        end
        if (alu_wr_s) begin
            zero_d = (alu_res_s == '0);
        end else begin
            zero_d = zero_q;
        end
        if (halt_hit_s) begin
            halt_pc_d = ir_pc_q;
        end else begin
            halt_pc_d = halt_pc_q;
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (exec_s && is_reserved(op_s));
`endif
    end

    // Pipeline and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            zero_q     <= 1'b0;
            halt_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= instruction;
            ir_pc_q    <= pc_q;
            ir_valid_q <= ir_valid_d;
            zero_q     <= zero_d;
            halt_pc_q  <= halt_pc_d;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Sticky trap flag, cleared only by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    assign zero = zero_q;

endmodule

// File: tb/tb_decode_exec.sv
// -----------------------------------------------------------------------------
// tb_decode_exec
// Drives decode_exec from a 16-word ROM with its own fetch PC and compares
// every execute cycle against an instruction-level reference model: the model
// walks the program one instruction at a time, inserts one dead cycle after
// each taken branch and spins once a HALT is reached.
// -----------------------------------------------------------------------------
module tb_decode_exec;

    localparam int DATA_W = 8;
    localparam int PC_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        instruction;
    logic              branch;
    logic [PC_W-1:0]   branchaddress;
    logic              reg_wr_en;
    logic [1:0]        reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              zero;
    logic              halted;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              illegal;
`endif

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] rom [16];
    logic [3:0] fpc;

    decode_exec #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .branch        (branch),
        .branchaddress (branchaddress),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .zero          (zero),
        .halted        (halted)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal       (illegal)
`endif
    );

    always #5 clk = ~clk;

    // Fetch ROM program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         fpc <= 4'd0;
        else if (branch) fpc <= branchaddress;
        else             fpc <= fpc + 4'd1;
    end

    assign instruction = rom[fpc];

    // ------------------------------------------------------- reference model
    int m_pc, m_halt_pc;
    bit m_bubble, m_halted, m_zero, m_illegal;
    int m_regs [4];
    int e_ba, e_waddr, e_wdata;
    bit e_branch, e_wen, e_zero, e_halted, e_illegal;

    task automatic model_reset();
        m_pc = 0; m_halt_pc = 0;
        m_bubble = 0; m_halted = 0; m_zero = 0; m_illegal = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
    endtask

    // Expected outputs for the current execute cycle, then advance the model
    task automatic model_step();
        int word, op, rd, rs, a, b, res;
        bit alu, stop, taken, rsv;
        e_zero = m_zero; e_halted = m_halted; e_illegal = m_illegal;
        e_branch = 0; e_ba = 0; e_wen = 0; e_waddr = 0; e_wdata = 0;
        if (m_halted) begin
            e_branch = 1; e_ba = m_halt_pc;
        end else if (m_bubble) begin
            m_bubble = 0;
        end else begin
            word = int'(rom[m_pc]);
            op = word / 16; rd = (word / 4) % 4; rs = word % 4;
            a = m_regs[rd]; b = m_regs[rs];
            alu = 1; res = 0;
            case (op)
                1: res = (a + 1) % 256;
                2: res = (a + b) % 256;
                3: res = (a - b + 256) % 256;
                4: res = b;
                5: res = a & b;
                6: res = a ^ b;
                default: alu = 0;
            endcase
            rsv = (op >= 7) && (op <= 11);
`ifdef DECODE_ILLEGAL_TRAP_EN
            stop = (op == 15) || rsv;
`else
            stop = (op == 15);
`endif
            taken = (op == 12) || (op == 13 && m_zero) || (op == 14 && !m_zero);
            if (alu) begin
                m_regs[rd] = res; m_zero = (res == 0);
                e_wen = 1; e_waddr = rd; e_wdata = res;
            end
            if (stop) begin
                e_branch = 1; e_ba = m_pc;
                m_halted = 1; m_halt_pc = m_pc;
                if (rsv) m_illegal = 1;
            end else if (taken) begin
                e_branch = 1; e_ba = word % 16;
                m_pc = word % 16; m_bubble = 1;
            end else begin
                m_pc = (m_pc + 1) % 16;
            end
        end
    endtask

    // ------------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_branch"}, 32'(branch), 32'd0);
        check({tag, "_ba"},     32'(branchaddress), 32'd0);
        check({tag, "_wen"},    32'(reg_wr_en), 32'd0);
        check({tag, "_waddr"},  32'(reg_wr_addr), 32'd0);
        check({tag, "_wdata"},  32'(reg_wr_data), 32'd0);
        check({tag, "_zero"},   32'(zero), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_step();
            check("branch", 32'(branch), 32'(e_branch));
            check("branchaddress", 32'(branchaddress), 32'(e_ba));
            check("reg_wr_en", 32'(reg_wr_en), 32'(e_wen));
            if (e_wen) begin
                check("reg_wr_addr", 32'(reg_wr_addr), 32'(e_waddr));
                check("reg_wr_data", 32'(reg_wr_data), 32'(e_wdata));
            end
            check("zero", 32'(zero), 32'(e_zero));
            check("halted", 32'(halted), 32'(e_halted));
`ifdef DECODE_ILLEGAL_TRAP_EN
            check("illegal", 32'(illegal), 32'(e_illegal));
`endif
        end
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs(tag);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic load_rom(input logic [7:0] p [16]);
        for (int i = 0; i < 16; i++) rom[i] = p[i];
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        logic [7:0] prog [16];

        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        // INC/ADD/SUB on R1, then JMP 8 from address 3 squashing address 4
        prog = '{8'h14, 8'h25, 8'h35, 8'hC8, 8'h18, 8'h00, 8'h00, 8'h00,
                 8'h1C, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        reset_dut("reset");
        run_cycles(4);
        check("p1_zero_after_sub", 32'(zero), 32'd1);
        check("p1_jmp_branch", 32'(branch), 32'd1);
        check("p1_jmp_target", 32'(branchaddress), 32'd8);
        run_cycles(1);
        check("p1_squash_no_write", 32'(reg_wr_en), 32'd0);
        run_cycles(1);
        check("p1_rom8_write_addr", 32'(reg_wr_addr), 32'd3);
        run_cycles(4);

        // JZ taken on zero=1, JZ not taken and JNZ taken after INC R0
        prog = '{8'h40, 8'hD5, 8'h1C, 8'h00, 8'h00, 8'h10, 8'hD5, 8'hEA,
                 8'h1C, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        reset_dut("reset_jz");
        run_cycles(2);
        check("jz_taken", 32'(branch), 32'd1);
        run_cycles(3);
        check("jz_not_taken", 32'(branch), 32'd0);
        run_cycles(1);
        check("jnz_taken", 32'(branchaddress), 32'd10);
        run_cycles(6);

        // HALT at address 6 holds for 12 cycles, then reset restarts fetch
        prog = '{8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h18,
                 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        reset_dut("reset_halt");
        run_cycles(7 + 12);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_ba", 32'(branchaddress), 32'd6);
        check("halt_no_write", 32'(reg_wr_en), 32'd0);
        reset_dut("reset_after_halt");
        check("fetch_restart", 32'(fpc), 32'd0);
        run_cycles(3);

        // Reset asserted while an ADD is executing: the write is dropped
        prog = '{8'h10, 8'h14, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        reset_dut("reset_mid");
        run_cycles(3);
        check("mid_add_wen", 32'(reg_wr_en), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        prog = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        model_reset();
        rst = 1'b0;
        run_cycles(4);
        check("mid_r3_was_zero", 32'(reg_wr_data), 32'd1);
        run_cycles(2);

        // Reserved opcode 9, then INC R2, then HALT
        prog = '{8'h90, 8'h18, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        reset_dut("reset_rsv");
        run_cycles(2);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("rsv_halted", 32'(halted), 32'd1);
        check("rsv_illegal", 32'(illegal), 32'd1);
`else
        check("rsv_nop_next_write", 32'(reg_wr_addr), 32'd2);
        check("rsv_nop_next_wen", 32'(reg_wr_en), 32'd1);
`endif
        run_cycles(3);

        // JMP to self: alternating execute / squash
        prog = '{8'h10, 8'hC1, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_rom(prog);
        reset_dut("reset_self");
        run_cycles(9);

        // Random programs
        for (int p = 0; p < 15; p++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            load_rom(prog);
            reset_dut("reset_rand");
            run_cycles(40);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
